// File: rtl/strfmt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : strfmt_pkg
//  Purpose  : Shared types, constants and sizing helpers for the streaming
//             integer-to-ASCII formatter (strfmt_itoa_stream).
//  Contents : radix_e, state_e, ASCII constants, digits_for_radix(),
//             max_digits(), bcd_width(), digit2ascii().
//  Revision : 1.0 - initial release
// ============================================================================
package strfmt_pkg;

  typedef enum logic [1:0] {
    RADIX_DEC = 2'd0,
    RADIX_HEX = 2'd1,
    RADIX_OCT = 2'd2,
    RADIX_BIN = 2'd3
  } radix_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SKIP = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A_LC  = 8'h61;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  // Digits needed to print a full-scale WIDTH-bit unsigned value.
  // Decimal uses ceil(width * log10(2)) with log10(2) ~= 0.30103.
  function automatic int digits_for_radix(input int width, input radix_e r);
    int n;
    case (r)
      RADIX_DEC: n = (width * 30103 + 99999) / 100000;
      RADIX_HEX: n = (width + 3) / 4;
      RADIX_OCT: n = (width + 2) / 3;
      default:   n = width;
    endcase
    return n;
  endfunction

  function automatic int max_digits(input int width);
    int m;
    m = digits_for_radix(width, RADIX_DEC);
    if (digits_for_radix(width, RADIX_HEX) > m) m = digits_for_radix(width, RADIX_HEX);
    if (digits_for_radix(width, RADIX_OCT) > m) m = digits_for_radix(width, RADIX_OCT);
    if (digits_for_radix(width, RADIX_BIN) > m) m = digits_for_radix(width, RADIX_BIN);
    return m;
  endfunction

  // One spare BCD digit of headroom so add-3 can never overflow the register.
  function automatic int bcd_width(input int width);
    return 4 * digits_for_radix(width, RADIX_DEC) + 4;
  endfunction

  function automatic logic [7:0] digit2ascii(input logic [3:0] d);
    logic [7:0] c;
    if (d < 4'd10) c = ASCII_ZERO + {4'b0000, d};
    else           c = ASCII_A_LC + {4'b0000, d} - 8'd10;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/strfmt_dabble.sv
`default_nettype none
// ============================================================================
//  Module   : strfmt_dabble
//  Purpose  : Binary-to-BCD double-dabble engine. One add-3 + shift iteration
//             per clock, exactly WIDTH iterations per conversion.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             start_i      - load value_i and begin a conversion
//             value_i      - WIDTH-bit unsigned operand
//             done_o       - high during the final iteration cycle; bcd_o is
//                            complete from the following cycle onward
//             bcd_o        - packed BCD result, held until the next start
//  Revision : 1.0 - initial release
// ============================================================================
module strfmt_dabble
  import strfmt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BCD_W = bcd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      bcd_d  = '0;
      bin_d  = value_i;
      cnt_d  = CNT_W'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Adjusted BCD and remaining binary shift together as one register.
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/strfmt_itoa_stream.sv
`default_nettype none
// ============================================================================
//  Module   : strfmt_itoa_stream
//  Purpose  : Streaming integer-to-ASCII formatter (itoa/hextoa/octtoa/
//             bintoa). Accepts one word + radix, emits its digit string
//             MSB-first as a byte stream with leading-zero suppression.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready   - request handshake (ready only in IDLE)
//             in_value, in_radix  - operand and radix (0 dec,1 hex,2 oct,3 bin)
//             in_signed           - two's complement decimal (optional)
//             out_valid/out_ready - byte handshake
//             out_data, out_last  - ASCII character, end-of-string marker
//  Config   : STRFMT_SIGNED_EN - when defined, negative signed decimal
//             values are negated and prefixed with '-'. When undefined,
//             in_signed is ignored and everything is formatted unsigned.
//  Revision : 1.0 - initial release
// ============================================================================
module strfmt_itoa_stream
  import strfmt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [1:0]       in_radix,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last
);

  localparam int NDIG_MAX = max_digits(WIDTH);
  localparam int BCD_W    = bcd_width(WIDTH);
  localparam int IDX_W    = (NDIG_MAX > 1) ? $clog2(NDIG_MAX) : 1;
  localparam int PAD_W    = 4 * NDIG_MAX;

  state_e           state_q;
  radix_e           radix_q;
  logic [WIDTH-1:0] value_q;
  logic             neg_q;
  logic             sign_out_q;   // currently presenting the '-' character
  logic [IDX_W-1:0] idx_q;        // digit index currently presented
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             out_last_q;

  logic             w_accept;
  radix_e           w_radix;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag;
  logic             w_eng_done;
  logic [BCD_W-1:0] w_eng_bcd;
  logic [PAD_W-1:0] w_vpad;
  logic [PAD_W-1:0] w_bpad;
  logic [3:0]       w_dig [NDIG_MAX];
  logic [IDX_W-1:0] w_top;
  logic [IDX_W-1:0] w_idx_prev;

  assign w_accept = (state_q == ST_IDLE) && in_valid;
  assign w_radix  = radix_e'(in_radix);

`ifdef STRFMT_SIGNED_EN
  // Negation is done in WIDTH-bit unsigned arithmetic, so the most negative
  // value maps onto its own (correct) unsigned magnitude.
  assign w_neg = in_signed && (w_radix == RADIX_DEC) && in_value[WIDTH-1];
  assign w_mag = w_neg ? (~in_value + WIDTH'(1)) : in_value;
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
  assign w_neg = 1'b0;
  assign w_mag = in_value;
`endif

  strfmt_dabble #(
    .WIDTH (WIDTH),
    .BCD_W (BCD_W)
  ) u_dabble (
    .clk     (clk),
    .rst     (rst),
    .start_i (w_accept && (w_radix == RADIX_DEC)),
    .value_i (w_mag),
    .done_o  (w_eng_done),
    .bcd_o   (w_eng_bcd)
  );

  // Digit select for every position plus the leading-digit encoder. Digits
  // above the natural width of a radix read zeros from the padding.
  always_comb begin
    w_vpad = '0;
    w_vpad[WIDTH-1:0] = value_q;
    w_bpad = '0;
    w_bpad[BCD_W-1:0] = w_eng_bcd;
    for (int i = 0; i < NDIG_MAX; i++) begin
      case (radix_q)
        RADIX_HEX: w_dig[i] = w_vpad[4*i +: 4];
        RADIX_OCT: w_dig[i] = {1'b0, w_vpad[3*i +: 3]};
        RADIX_BIN: w_dig[i] = {3'b000, w_vpad[i]};
        default:   w_dig[i] = w_bpad[4*i +: 4];
      endcase
    end
    // Highest nonzero digit wins; all-zero leaves index 0 so a lone '0' prints.
    w_top = '0;
    for (int i = 0; i < NDIG_MAX; i++) begin
      if (w_dig[i] != 4'd0) w_top = IDX_W'(i);
    end
  end

  assign w_idx_prev = idx_q - IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      radix_q     <= RADIX_DEC;
      value_q     <= '0;
      neg_q       <= 1'b0;
      sign_out_q  <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            value_q <= w_mag;
            radix_q <= w_radix;
            neg_q   <= w_neg;
            state_q <= (w_radix == RADIX_DEC) ? ST_CONV : ST_SKIP;
          end
        end
        ST_CONV: begin
          if (w_eng_done) state_q <= ST_SKIP;
        end
        ST_SKIP: begin
          state_q     <= ST_EMIT;
          out_valid_q <= 1'b1;
          idx_q       <= w_top;
          if (neg_q) begin
            sign_out_q <= 1'b1;
            out_data_q <= ASCII_MINUS;
            out_last_q <= 1'b0;
          end else begin
            sign_out_q <= 1'b0;
            out_data_q <= digit2ascii(w_dig[w_top]);
            out_last_q <= (w_top == '0);
          end
        end
        default: begin // ST_EMIT
          if (out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= ST_IDLE;
            end else if (sign_out_q) begin
              sign_out_q <= 1'b0;
              out_data_q <= digit2ascii(w_dig[idx_q]);
              out_last_q <= (idx_q == '0);
            end else begin
              idx_q      <= w_idx_prev;
              out_data_q <= digit2ascii(w_dig[w_idx_prev]);
              out_last_q <= (w_idx_prev == '0);
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_strfmt_itoa_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_strfmt_itoa_stream
//  Purpose  : Directed self-checking bench for strfmt_itoa_stream (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_strfmt_itoa_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [1:0]  in_radix;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int checks = 0;
  int passes = 0;

  strfmt_itoa_stream #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_radix  (in_radix),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Present one request at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] v, input logic [1:0] r, input logic sg, output bit to);
    int n;
    to = 0;
    n  = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) to = 1;
    in_valid  = 1'b1;
    in_value  = v;
    in_radix  = r;
    in_signed = sg;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drains one string with out_ready high pct% of cycles. Reports latency
  // (cycles after the accept cycle), position of out_last, stall stability and
  // whether in_ready rose before the last byte was taken.
  task automatic collect(input int pct, output string s, output int lat, output int lastpos,
                         output bit unstable, output bit early_ready, output bit to);
    bit         done;
    bit         pstall;
    logic [7:0] pdata;
    logic       plast;
    int         n;
    s = ""; lat = 1; lastpos = -1; unstable = 0; early_ready = 0; to = 0;
    done = 0; pstall = 0; pdata = 8'h00; plast = 1'b0; n = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) early_ready = 1;
      @(negedge clk);
      lat++;
    end
    while (!done && n < 400) begin
      if (in_ready) early_ready = 1;
      if (pstall && (out_valid !== 1'b1 || out_data !== pdata || out_last !== plast)) unstable = 1;
      out_ready = ($urandom_range(99) < pct);
      if (out_valid && out_ready) begin
        s = {s, $sformatf("%c", out_data)};
        if (out_last) begin
          lastpos  = s.len();
          done     = 1;
          in_valid = 1'b0;
        end
      end
      pstall = out_valid && !out_ready;
      pdata  = out_data;
      plast  = out_last;
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    if (!done) to = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_radix = 2'd0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", out_last); else passes++;
  endtask

  task automatic test_dec_basic;
    string s; int lat, lp; bit un, er, to, tos;
    send(32'd123, 2'd0, 1'b0, tos);
    collect(100, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != "123") $display("FAIL dec123_str got=%s exp=123", s); else passes++;
    checks++; if (lat != 34) $display("FAIL dec123_latency got=%0d exp=34", lat); else passes++;
    checks++; if (lp != 3) $display("FAIL dec123_lastpos got=%0d exp=3", lp); else passes++;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || er)
      $display("FAIL dec123_return_idle got=rdy%b vld%b early%b exp=rdy1 vld0 early0", in_ready, out_valid, er);
    else passes++;
  endtask

  task automatic test_pow2;
    string      exp_s [3] = '{"7b", "173", "1111011"};
    logic [1:0] rad   [3] = '{2'd1, 2'd2, 2'd3};
    string s; int lat, lp; bit un, er, to, tos;
    for (int i = 0; i < 3; i++) begin
      send(32'd123, rad[i], 1'b0, tos);
      collect(100, s, lat, lp, un, er, to);
      checks++; if (to || tos || s != exp_s[i]) $display("FAIL pow2_str radix=%0d got=%s exp=%s", rad[i], s, exp_s[i]); else passes++;
      checks++; if (lat != 2) $display("FAIL pow2_latency radix=%0d got=%0d exp=2", rad[i], lat); else passes++;
      checks++; if (lp != exp_s[i].len()) $display("FAIL pow2_lastpos radix=%0d got=%0d exp=%0d", rad[i], lp, exp_s[i].len()); else passes++;
    end
  endtask

  task automatic test_zero;
    string s; int lat, lp; bit un, er, to, tos;
    for (int r = 0; r < 4; r++) begin
      send(32'd0, 2'(r), 1'b0, tos);
      collect(100, s, lat, lp, un, er, to);
      checks++; if (to || tos || s != "0") $display("FAIL zero_str radix=%0d got=%s exp=0", r, s); else passes++;
      checks++; if (lp != 1) $display("FAIL zero_lastpos radix=%0d got=%0d exp=1", r, lp); else passes++;
    end
  endtask

  task automatic test_all_ones;
    string s; int lat, lp; bit un, er, to, tos;
    send(32'hFFFF_FFFF, 2'd0, 1'b0, tos);
    collect(100, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != "4294967295") $display("FAIL allones_dec got=%s exp=4294967295", s); else passes++;
    send(32'hFFFF_FFFF, 2'd2, 1'b0, tos);
    collect(100, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != "37777777777") $display("FAIL allones_oct got=%s exp=37777777777", s); else passes++;
  endtask

  task automatic test_back_to_back_stall;
    string s; int lat, lp; bit un, er, to, tos;
    send(32'd987654321, 2'd0, 1'b0, tos);
    // A competing request held high while busy must be ignored.
    in_valid = 1'b1; in_value = 32'd5; in_radix = 2'd1;
    collect(50, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != "987654321") $display("FAIL stall_str got=%s exp=987654321", s); else passes++;
    checks++; if (un) $display("FAIL stall_stable got=changed exp=held"); else passes++;
    checks++; if (er) $display("FAIL stall_in_ready got=high_while_busy exp=low"); else passes++;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_no_spurious got=vld%b rdy%b exp=vld0 rdy1", out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_reset_mid;
    string s; int lat, lp, n; bit un, er, to, tos;
    send(32'h1234_5678, 2'd0, 1'b0, tos);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_conv got=vld%b rdy%b exp=vld0 rdy1", out_valid, in_ready);
    else passes++;
    send(32'd123456789, 2'd0, 1'b0, tos);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h33)
      $display("FAIL rst_emit_pre got=vld%b data%h exp=vld1 data33", out_valid, out_data);
    else passes++;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rst_emit got=vld%b rdy%b exp=vld0 rdy1", out_valid, in_ready);
    else passes++;
    send(32'h0000_DEAD, 2'd1, 1'b0, tos);
    collect(100, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != "dead") $display("FAIL rst_then_hex got=%s exp=dead", s); else passes++;
  endtask

  task automatic test_signed;
    string s; int lat, lp; bit un, er, to, tos;
    string e1, e2;
`ifdef STRFMT_SIGNED_EN
    e1 = "-123";
    e2 = "-2147483648";
`else
    e1 = "4294967173";
    e2 = "2147483648";
`endif
    send(32'hFFFF_FF85, 2'd0, 1'b1, tos);
    collect(100, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != e1) $display("FAIL signed_m123 got=%s exp=%s", s, e1); else passes++;
    checks++; if (lp != e1.len()) $display("FAIL signed_m123_last got=%0d exp=%0d", lp, e1.len()); else passes++;
    send(32'h8000_0000, 2'd0, 1'b1, tos);
    collect(100, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != e2) $display("FAIL signed_min got=%s exp=%s", s, e2); else passes++;
    send(32'hFFFF_FFFF, 2'd1, 1'b1, tos);
    collect(100, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != "ffffffff") $display("FAIL signed_hex got=%s exp=ffffffff", s); else passes++;
    send(32'd42, 2'd0, 1'b1, tos);
    collect(100, s, lat, lp, un, er, to);
    checks++; if (to || tos || s != "42") $display("FAIL signed_pos got=%s exp=42", s); else passes++;
  endtask

  initial begin
    test_reset();
    test_dec_basic();
    test_pow2();
    test_zero();
    test_all_ones();
    test_back_to_back_stall();
    test_reset_mid();
    test_signed();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
